// File: rtl/global_defs.sv
// Shared memory-bus types for the KNN processor <-> memory interface.
// Holds the command encoding, tag/data/address widths and bus constants.
// Ports: none (package).
package global_defs;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } MEM_COMMAND;

  typedef logic [3:0]  MEM_TAG;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [31:0] ADDR;

  localparam MEM_TAG MEM_TAG_NONE   = 4'd0;
  localparam int     MEM_WORD_SHIFT = 3;

endpackage

// File: rtl/knn_mem_responder_pkg.sv
// Responder-local constants and the lowest-free-tag priority encoder.
// Ports: none (package).
// Tag widths come from global_defs; MAX_TAGS is the most a 4-bit tag can name.
package knn_mem_responder_pkg;
  import global_defs::*;

  localparam int MAX_TAGS    = 15;
  localparam int MAX_LATENCY = 16;

  // Returns the lowest tag whose bit is set in free_mask (bit i = tag i+1),
  // or MEM_TAG_NONE when nothing is free.
  function automatic MEM_TAG lowest_free(input logic [MAX_TAGS-1:0] free_mask);
    MEM_TAG tag;
    tag = MEM_TAG_NONE;
    for (int i = MAX_TAGS - 1; i >= 0; i--) begin
      if (free_mask[i]) tag = MEM_TAG'(i + 1);
    end
    return tag;
  endfunction

endpackage

// File: rtl/mem_tag_allocator.sv
// Tag pool: busy vector of NUM_TAGS bits, grants the lowest free tag.
// Ports: clk/rst; alloc_vld claims grant_tag at the edge; free_vld/free_tag
// release a tag at the edge. grant_tag is combinational, 0 when none free.
module mem_tag_allocator
  import global_defs::*;
  import knn_mem_responder_pkg::*;
#(
  parameter int NUM_TAGS = 15
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   alloc_vld,
  input  logic   free_vld,
  input  MEM_TAG free_tag,
  output MEM_TAG grant_tag
);

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [MAX_TAGS-1:0] free_mask;

  // Grant is computed from the registered busy vector, so a tag released
  // this cycle cannot be handed out again until the next cycle.
  always_comb begin
    free_mask = '0;
    free_mask[NUM_TAGS-1:0] = ~busy_q;
  end

  assign grant_tag = lowest_free(free_mask);

  // The granted tag is never busy and the freed tag always is, so a
  // same-cycle alloc and free always touch different bits.
  always_comb begin
    busy_d = busy_q;
    for (int i = 0; i < NUM_TAGS; i++) begin
      if (free_vld && free_tag == MEM_TAG'(i + 1)) busy_d[i] = 1'b0;
      if (alloc_vld && grant_tag == MEM_TAG'(i + 1)) busy_d[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

endmodule

// File: rtl/knn_mem_responder.sv
// Tagged memory responder: one LOAD/STORE per cycle, tag granted same cycle,
// load data returned with its tag exactly LATENCY cycles after issue.
// Ports: clk, rst (sync, active-high); proc2mem_command/addr/data in;
// mem2proc_transaction_tag (comb), mem2proc_data/_data_tag (registered) out.
// Optional KNN_MEM_STATS_EN adds saturating stat_loads/stat_stores/stat_rejects.
module knn_mem_responder
  import global_defs::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 4,
  parameter int NUM_TAGS  = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  MEM_COMMAND proc2mem_command,
  input  ADDR        proc2mem_addr,
  input  MEM_BLOCK   proc2mem_data,
  output MEM_TAG     mem2proc_transaction_tag,
  output MEM_BLOCK   mem2proc_data,
  output MEM_TAG     mem2proc_data_tag
`ifdef KNN_MEM_STATS_EN
  ,
  output logic [31:0] stat_loads,
  output logic [31:0] stat_stores,
  output logic [31:0] stat_rejects
`endif
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  // Array contents survive rst, so the store port has no reset branch.
  MEM_BLOCK mem_q [MEM_WORDS];

  logic     is_load, is_store;
  logic     in_range, load_acc;
  ADDR      addr_word;
  MEM_BLOCK rd_dat;
  MEM_TAG   grant_tag;

  MEM_TAG   pipe_tag_q [LATENCY];
  MEM_TAG   pipe_tag_d [LATENCY];
  MEM_BLOCK pipe_dat_q [LATENCY];
  MEM_BLOCK pipe_dat_d [LATENCY];
  MEM_TAG   src_tag    [LATENCY];
  MEM_BLOCK src_dat    [LATENCY];

  // Commands are ignored while rst is high; illegal encodings fall to NONE.
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    if (!rst) begin
      case (proc2mem_command)
        BUS_LOAD:  is_load  = 1'b1;
        BUS_STORE: is_store = 1'b1;
        default:   ;
      endcase
    end
  end

  assign addr_word = proc2mem_addr >> MEM_WORD_SHIFT;
  assign in_range  = addr_word < ADDR'(MEM_WORDS);

  // Read happens at issue, before this cycle's write lands at the edge.
  assign rd_dat = in_range ? mem_q[addr_word[IDX_W-1:0]] : '0;

  always_ff @(posedge clk) begin
    if (is_store && in_range) mem_q[addr_word[IDX_W-1:0]] <= proc2mem_data;
  end

  assign load_acc                 = is_load && (grant_tag != MEM_TAG_NONE);
  assign mem2proc_transaction_tag = load_acc ? grant_tag : MEM_TAG_NONE;

  mem_tag_allocator #(
    .NUM_TAGS (NUM_TAGS)
  ) u_tag_alloc (
    .clk       (clk),
    .rst       (rst),
    .alloc_vld (load_acc),
    .free_vld  (mem2proc_data_tag != MEM_TAG_NONE),
    .free_tag  (mem2proc_data_tag),
    .grant_tag (grant_tag)
  );

  // LATENCY-deep shift line; the last stage is the registered output.
  // Data registers only move when a real entry passes through, which keeps
  // mem2proc_data at its last returned value between responses.
  always_comb begin
    src_tag[0] = mem2proc_transaction_tag;
    src_dat[0] = rd_dat;
    for (int k = 1; k < LATENCY; k++) begin
      src_tag[k] = pipe_tag_q[k-1];
      src_dat[k] = pipe_dat_q[k-1];
    end
    for (int k = 0; k < LATENCY; k++) begin
      pipe_tag_d[k] = src_tag[k];
      pipe_dat_d[k] = (src_tag[k] != MEM_TAG_NONE) ? src_dat[k] : pipe_dat_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_tag_q[k] <= MEM_TAG_NONE;
        pipe_dat_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < LATENCY; k++) begin
        pipe_tag_q[k] <= pipe_tag_d[k];
        pipe_dat_q[k] <= pipe_dat_d[k];
      end
    end
  end

  assign mem2proc_data_tag = pipe_tag_q[LATENCY-1];
  assign mem2proc_data     = pipe_dat_q[LATENCY-1];

`ifdef KNN_MEM_STATS_EN
  logic [31:0] stat_loads_q,   stat_loads_d;
  logic [31:0] stat_stores_q,  stat_stores_d;
  logic [31:0] stat_rejects_q, stat_rejects_d;

  always_comb begin
    stat_loads_d   = stat_loads_q;
    stat_stores_d  = stat_stores_q;
    stat_rejects_d = stat_rejects_q;
    if (load_acc && stat_loads_q != '1)                stat_loads_d   = stat_loads_q + 32'd1;
    if (is_store && stat_stores_q != '1)               stat_stores_d  = stat_stores_q + 32'd1;
    if (is_load && !load_acc && stat_rejects_q != '1)  stat_rejects_d = stat_rejects_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_loads_q   <= '0;
      stat_stores_q  <= '0;
      stat_rejects_q <= '0;
    end else begin
      stat_loads_q   <= stat_loads_d;
      stat_stores_q  <= stat_stores_d;
      stat_rejects_q <= stat_rejects_d;
    end
  end

  assign stat_loads   = stat_loads_q;
  assign stat_stores  = stat_stores_q;
  assign stat_rejects = stat_rejects_q;
`endif

endmodule

// File: tb/tb_knn_mem_responder.sv
// Directed bench for knn_mem_responder: one instance at LATENCY=4 for the
// main flows and one at LATENCY=16 for tag exhaustion.
// Ports: none (top-level bench).
module tb_knn_mem_responder;
  import global_defs::*;

  localparam MEM_BLOCK D_RT = 64'hDEADBEEF_CAFEF00D;

  logic       clk;
  logic       rst;
  MEM_COMMAND a_cmd,  b_cmd;
  ADDR        a_addr, b_addr;
  MEM_BLOCK   a_wdat, b_wdat;
  MEM_TAG     a_ttag, b_ttag;
  MEM_BLOCK   a_rdat, b_rdat;
  MEM_TAG     a_dtag, b_dtag;

  int n_checks = 0;
  int n_errors = 0;

`ifdef KNN_MEM_STATS_EN
  logic [31:0] a_sl, a_ss, a_sr, b_sl, b_ss, b_sr;
`endif

  knn_mem_responder #(.MEM_WORDS(1024), .LATENCY(4), .NUM_TAGS(15)) dut_a (
    .clk                      (clk),
    .rst                      (rst),
    .proc2mem_command         (a_cmd),
    .proc2mem_addr            (a_addr),
    .proc2mem_data            (a_wdat),
    .mem2proc_transaction_tag (a_ttag),
    .mem2proc_data            (a_rdat),
    .mem2proc_data_tag        (a_dtag)
`ifdef KNN_MEM_STATS_EN
    , .stat_loads(a_sl), .stat_stores(a_ss), .stat_rejects(a_sr)
`endif
  );

  knn_mem_responder #(.MEM_WORDS(1024), .LATENCY(16), .NUM_TAGS(15)) dut_b (
    .clk                      (clk),
    .rst                      (rst),
    .proc2mem_command         (b_cmd),
    .proc2mem_addr            (b_addr),
    .proc2mem_data            (b_wdat),
    .mem2proc_transaction_tag (b_ttag),
    .mem2proc_data            (b_rdat),
    .mem2proc_data_tag        (b_dtag)
`ifdef KNN_MEM_STATS_EN
    , .stat_loads(b_sl), .stat_stores(b_ss), .stat_rejects(b_sr)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One cycle on instance A: drive just after the edge, check at the falling edge.
  task automatic cyc_a(input MEM_COMMAND cmd, input ADDR addr, input MEM_BLOCK wdat,
                       input MEM_TAG exp_tt, input MEM_TAG exp_dt,
                       input logic chk_dat, input MEM_BLOCK exp_dat, input string name);
    a_cmd  = cmd;
    a_addr = addr;
    a_wdat = wdat;
    @(negedge clk);
    check({name, ".ttag"}, 64'(a_ttag), 64'(exp_tt));
    check({name, ".dtag"}, 64'(a_dtag), 64'(exp_dt));
    if (chk_dat) check({name, ".data"}, a_rdat, exp_dat);
    @(posedge clk);
    #1;
    a_cmd = BUS_NONE;
  endtask

  task automatic cyc_b(input MEM_COMMAND cmd, input ADDR addr, input MEM_BLOCK wdat,
                       input MEM_TAG exp_tt, input MEM_TAG exp_dt,
                       input logic chk_dat, input MEM_BLOCK exp_dat, input string name);
    b_cmd  = cmd;
    b_addr = addr;
    b_wdat = wdat;
    @(negedge clk);
    check({name, ".ttag"}, 64'(b_ttag), 64'(exp_tt));
    check({name, ".dtag"}, 64'(b_dtag), 64'(exp_dt));
    if (chk_dat) check({name, ".data"}, b_rdat, exp_dat);
    @(posedge clk);
    #1;
    b_cmd = BUS_NONE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    MEM_TAG   et, ed;
    MEM_BLOCK edat;

    rst    = 1'b1;
    a_cmd  = BUS_NONE; a_addr = '0; a_wdat = '0;
    b_cmd  = BUS_NONE; b_addr = '0; b_wdat = '0;
    repeat (2) @(posedge clk);
    #1;

    // A LOAD while rst is high must not be granted; outputs are reset.
    cyc_a(BUS_LOAD, 32'h0, '0, 4'd0, 4'd0, 1'b1, 64'h0, "rst_load");
    check("rst_b.dtag", 64'(b_dtag), 64'h0);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++)
      cyc_a(BUS_NONE, 32'h0, '0, 4'd0, 4'd0, 1'b1, 64'h0, $sformatf("idle%0d", i));

    // Store/load round trip.
    cyc_a(BUS_STORE, 32'h40, D_RT, 4'd0, 4'd0, 1'b0, '0, "rt_st");
    cyc_a(BUS_LOAD,  32'h40, '0,   4'd1, 4'd0, 1'b0, '0, "rt_ld");
    cyc_a(BUS_NONE,  32'h0,  '0,   4'd0, 4'd0, 1'b1, 64'h0, "rt_w1");
    cyc_a(BUS_NONE,  32'h0,  '0,   4'd0, 4'd0, 1'b0, '0, "rt_w2");
    cyc_a(BUS_NONE,  32'h0,  '0,   4'd0, 4'd0, 1'b0, '0, "rt_w3");
    cyc_a(BUS_NONE,  32'h0,  '0,   4'd0, 4'd1, 1'b1, D_RT, "rt_rsp");

    // Fill words 0..19 with 0x1000+i (data output keeps holding D_RT).
    for (int i = 0; i < 20; i++)
      cyc_a(BUS_STORE, ADDR'(i * 8), 64'h1000 + 64'(i), 4'd0, 4'd0, 1'b1, D_RT,
            $sformatf("fill%0d", i));

    // Streaming: tags 1..5 repeat, each response 4 cycles after its issue.
    for (int i = 0; i < 25; i++) begin
      et   = (i < 20) ? MEM_TAG'(i % 5 + 1) : 4'd0;
      ed   = (i >= 4 && i < 24) ? MEM_TAG'((i - 4) % 5 + 1) : 4'd0;
      edat = (i < 4) ? D_RT : (i < 24) ? 64'h1000 + 64'(i - 4) : 64'h1000 + 64'd19;
      cyc_a((i < 20) ? BUS_LOAD : BUS_NONE, ADDR'(i * 8), '0, et, ed, 1'b1, edat,
            $sformatf("strm%0d", i));
    end

    // Hazard: in-flight load sees the old word, later load sees the new one.
    cyc_a(BUS_STORE, 32'h80, 64'h11, 4'd0, 4'd0, 1'b0, '0, "hz_init");
    cyc_a(BUS_LOAD,  32'h80, '0,     4'd1, 4'd0, 1'b0, '0, "hz_ld0");
    cyc_a(BUS_STORE, 32'h80, 64'h22, 4'd0, 4'd0, 1'b0, '0, "hz_st");
    cyc_a(BUS_LOAD,  32'h80, '0,     4'd2, 4'd0, 1'b0, '0, "hz_ld1");
    cyc_a(BUS_NONE,  32'h0,  '0,     4'd0, 4'd0, 1'b0, '0, "hz_w");
    cyc_a(BUS_NONE,  32'h0,  '0,     4'd0, 4'd1, 1'b1, 64'h11, "hz_rsp0");
    cyc_a(BUS_NONE,  32'h0,  '0,     4'd0, 4'd0, 1'b1, 64'h11, "hz_hold");
    cyc_a(BUS_NONE,  32'h0,  '0,     4'd0, 4'd2, 1'b1, 64'h22, "hz_rsp1");

    // Out-of-range word and illegal command encoding.
    cyc_a(BUS_STORE, 32'h2000, 64'h55, 4'd0, 4'd0, 1'b0, '0, "oor_st");
    cyc_a(BUS_LOAD,  32'h2000, '0,     4'd1, 4'd0, 1'b0, '0, "oor_ld");
    cyc_a(BUS_LOAD,  32'h0,    '0,     4'd2, 4'd0, 1'b0, '0, "oor_ld0");
    cyc_a(MEM_COMMAND'(2'h3), 32'h0, '0, 4'd0, 4'd0, 1'b0, '0, "illegal");
    cyc_a(BUS_NONE,  32'h0,    '0,     4'd0, 4'd0, 1'b0, '0, "oor_w");
    cyc_a(BUS_NONE,  32'h0,    '0,     4'd0, 4'd1, 1'b1, 64'h0, "oor_rsp");
    cyc_a(BUS_NONE,  32'h0,    '0,     4'd0, 4'd2, 1'b1, 64'h1000, "oor_alias");
    cyc_a(BUS_NONE,  32'h0,    '0,     4'd0, 4'd0, 1'b0, '0, "illegal_rsp");

    // Reset mid-flight: three loads dropped, array contents kept.
    cyc_a(BUS_LOAD, 32'h40, '0, 4'd1, 4'd0, 1'b0, '0, "mf_ld0");
    cyc_a(BUS_LOAD, 32'h8,  '0, 4'd2, 4'd0, 1'b0, '0, "mf_ld1");
    cyc_a(BUS_LOAD, 32'h10, '0, 4'd3, 4'd0, 1'b0, '0, "mf_ld2");
    rst = 1'b1;
    cyc_a(BUS_NONE, 32'h0,  '0, 4'd0, 4'd0, 1'b0, '0, "mf_rst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++)
      cyc_a(BUS_NONE, 32'h0, '0, 4'd0, 4'd0, 1'b1, 64'h0, $sformatf("mf_q%0d", i));
    cyc_a(BUS_LOAD, 32'h80, '0, 4'd1, 4'd0, 1'b0, '0, "mf_post");
    for (int i = 0; i < 3; i++)
      cyc_a(BUS_NONE, 32'h0, '0, 4'd0, 4'd0, 1'b0, '0, $sformatf("mf_w%0d", i));
    cyc_a(BUS_NONE, 32'h0, '0, 4'd0, 4'd1, 1'b1, 64'h22, "mf_rsp");

    // Exhaustion on the LATENCY=16 instance.
    cyc_b(BUS_STORE, 32'h0, 64'hAB, 4'd0, 4'd0, 1'b0, '0, "ex_st");
    for (int i = 0; i < 35; i++) begin
      if (i < 15)       et = MEM_TAG'(i + 1);
      else if (i == 17) et = 4'd1;
      else              et = 4'd0;
      if (i == 16)                ed = 4'd1;
      else if (i >= 17 && i <= 30) ed = MEM_TAG'(i - 15);
      else if (i == 33)           ed = 4'd1;
      else                        ed = 4'd0;
      cyc_b((i <= 17) ? BUS_LOAD : BUS_NONE, 32'h0, '0, et, ed, (ed != 4'd0), 64'hAB,
            $sformatf("ex%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
